// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the decoded bundle.
// The bundle layout is also consumed by the execute stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        alu_src_imm;
        logic        lui;
        logic        auipc;
        logic        illegal;
    } id_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction, sign-extended to 32 bits; purely combinational.
// The opcode bits are not needed here, so only instr[31:7] is taken.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: 1-cycle registered bundle, holds while execute stalls, if_ready = !id_valid || ex_ready.
// Redirects fetch on JAL and drops the next SQUASH_BEATS wrong-path beats; flush kills bundle and squash.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int SQUASH_BEATS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        jump,
    output logic [31:0] pc_imm,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [31:0] id_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jal,
    output logic        id_jalr,
    output logic        id_alu_src_imm,
    output logic        id_lui,
    output logic        id_auipc,
    output logic        id_illegal
);

    localparam int CW = $clog2(SQUASH_BEATS + 2);

    logic [CW-1:0] squash_cnt;
    id_bundle_t    bundle;
    id_bundle_t    dec;
    imm_fmt_t      fmt;
    logic [31:0]   imm;
    logic          accept;
    logic          drop;
    logic          is_jal;

    assign if_ready = !id_valid || ex_ready;
    assign accept   = if_valid && if_ready && !flush && (squash_cnt == '0);
    assign drop     = if_valid && if_ready && !flush && (squash_cnt != '0);
    assign is_jal   = (if_instr[6:0] == OPC_JAL);

    always_comb begin
        fmt = IMM_NONE;
        case (if_instr[6:0])
            OPC_LUI, OPC_AUIPC:               fmt = IMM_U;
            OPC_JAL:                          fmt = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:   fmt = IMM_I;
            OPC_BRANCH:                       fmt = IMM_B;
            OPC_STORE:                        fmt = IMM_S;
            default:                          fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (if_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        dec        = '0;
        dec.pc     = if_pc;
        dec.rd     = if_instr[11:7];
        dec.funct3 = if_instr[14:12];
        dec.rs1    = if_instr[19:15];
        dec.rs2    = if_instr[24:20];
        dec.funct7 = if_instr[31:25];
        dec.imm    = imm;
        case (if_instr[6:0])
            OPC_LUI: begin
                dec.reg_write   = 1'b1;
                dec.lui         = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec.reg_write   = 1'b1;
                dec.auipc       = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.jal       = 1'b1;
            end
            OPC_JALR: begin
                dec.reg_write   = 1'b1;
                dec.jalr        = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: dec.branch = 1'b1;
            OPC_LOAD: begin
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_OP:    dec.reg_write = 1'b1;
            OPC_FENCE: dec.reg_write = 1'b0;
            // every legal opcode ends in 2'b11, so this also catches compressed encodings
            default:   dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bundle     <= '0;
            id_valid   <= 1'b0;
            jump       <= 1'b0;
            pc_imm     <= '0;
            squash_cnt <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            jump       <= 1'b0;
            squash_cnt <= '0;
        end else begin
            jump <= accept && is_jal;
            if (accept) begin
                bundle   <= dec;
                id_valid <= 1'b1;
                if (is_jal) begin
                    pc_imm     <= if_pc + imm;
                    squash_cnt <= CW'(SQUASH_BEATS);
                end
            end else begin
                if (ex_ready) begin
                    id_valid <= 1'b0;
                end
                if (drop) begin
                    squash_cnt <= squash_cnt - CW'(1);
                end
            end
        end
    end

    assign id_pc          = bundle.pc;
    assign id_rs1         = bundle.rs1;
    assign id_rs2         = bundle.rs2;
    assign id_rd          = bundle.rd;
    assign id_funct3      = bundle.funct3;
    assign id_funct7      = bundle.funct7;
    assign id_imm         = bundle.imm;
    assign id_reg_write   = bundle.reg_write;
    assign id_mem_read    = bundle.mem_read;
    assign id_mem_write   = bundle.mem_write;
    assign id_branch      = bundle.branch;
    assign id_jal         = bundle.jal;
    assign id_jalr        = bundle.jalr;
    assign id_alu_src_imm = bundle.alu_src_imm;
    assign id_lui         = bundle.lui;
    assign id_auipc       = bundle.auipc;
    assign id_illegal     = bundle.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed steps from the decode/redirect scenarios, then random traffic,
// all checked against a cycle-level reference model of the stage's rules.
module tb_id_stage;

    localparam int SQ = 2;

    logic        clk = 1'b0;
    logic        reset, if_valid, ex_ready, flush;
    logic [31:0] if_pc, if_instr;
    logic        if_ready, jump, id_valid;
    logic [31:0] pc_imm, id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr;
    logic        id_alu_src_imm, id_lui, id_auipc, id_illegal;

    always #5 clk = ~clk;

    id_stage #(.SQUASH_BEATS(SQ)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush), .jump(jump), .pc_imm(pc_imm),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr),
        .id_alu_src_imm(id_alu_src_imm), .id_lui(id_lui), .id_auipc(id_auipc),
        .id_illegal(id_illegal)
    );

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic wr, mr, mw, br, jal, jalr, src, lui, auipc, ill;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t m_b;
    logic m_valid = 1'b0, m_jump = 1'b0, m_zero = 1'b0;
    logic [31:0] m_pc_imm = '0;
    int   m_sq = 0;

    // Reference decode: immediates built from weighted bit fields, sign bit carrying its negative weight.
    function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] pc);
        exp_t e;
        int   imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = (i[31] ? -2048 : 0) + int'(i[30:20]);
        imm_s = (i[31] ? -2048 : 0) + (int'(i[30:25]) << 5) + int'(i[11:7]);
        imm_b = (i[31] ? -4096 : 0) + (int'(i[7]) << 11) + (int'(i[30:25]) << 5) + (int'(i[11:8]) << 1);
        imm_u = int'(i[31:12]) << 12;
        imm_j = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12) + (int'(i[20]) << 11)
                + (int'(i[30:21]) << 1);
        e = '{pc: pc, imm: 0, rs1: i[19:15], rs2: i[24:20], rd: i[11:7], f3: i[14:12], f7: i[31:25],
              wr: 0, mr: 0, mw: 0, br: 0, jal: 0, jalr: 0, src: 0, lui: 0, auipc: 0, ill: 0};
        case (i[6:0])
            7'h37: begin e.imm = imm_u; e.wr = 1; e.lui = 1; e.src = 1; end
            7'h17: begin e.imm = imm_u; e.wr = 1; e.auipc = 1; e.src = 1; end
            7'h6F: begin e.imm = imm_j; e.wr = 1; e.jal = 1; end
            7'h67: begin e.imm = imm_i; e.wr = 1; e.jalr = 1; e.src = 1; end
            7'h63: begin e.imm = imm_b; e.br = 1; end
            7'h03: begin e.imm = imm_i; e.wr = 1; e.mr = 1; e.src = 1; end
            7'h23: begin e.imm = imm_s; e.mw = 1; e.src = 1; end
            7'h13: begin e.imm = imm_i; e.wr = 1; e.src = 1; end
            7'h33: e.wr = 1;
            7'h0F: e.wr = 0;
            default: e.ill = 1;
        endcase
        if (i[11:7] == 5'd0) e.wr = 0;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: predict from the inputs now applied, clock, then compare.
    task automatic cycle();
        logic rdy, acc;
        exp_t d;
        #1;
        rdy = !m_valid || ex_ready;
        if (!reset) chk("if_ready", if_ready, rdy);
        if (reset) begin
            m_b = ref_decode(32'h0, 32'h0);
            m_b.rd = 0; m_b.rs1 = 0; m_b.rs2 = 0; m_b.ill = 0;
            m_valid = 0; m_jump = 0; m_pc_imm = 0; m_sq = 0; m_zero = 1;
        end else if (flush) begin
            m_valid = 0; m_jump = 0; m_sq = 0;
        end else begin
            acc = if_valid && rdy && (m_sq == 0);
            m_jump = 0;
            if (acc) begin
                d = ref_decode(if_instr, if_pc);
                m_b = d; m_valid = 1; m_zero = 0;
                if (d.jal) begin
                    m_jump = 1; m_pc_imm = if_pc + d.imm; m_sq = SQ;
                end
            end else begin
                if (m_valid && ex_ready) m_valid = 0;
                if (if_valid && rdy && m_sq > 0) m_sq--;
            end
        end
        @(posedge clk);
        #1;
        chk("id_valid", id_valid, m_valid);
        chk("jump", jump, m_jump);
        chk("pc_imm", pc_imm, m_pc_imm);
        if (m_valid || m_zero) begin
            chk("id_pc", id_pc, m_b.pc);
            chk("id_imm", id_imm, m_b.imm);
            chk("id_regs", {id_rs1, id_rs2, id_rd}, {m_b.rs1, m_b.rs2, m_b.rd});
            chk("id_funct", {id_funct3, id_funct7}, {m_b.f3, m_b.f7});
            chk("id_flags",
                {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr,
                 id_alu_src_imm, id_lui, id_auipc, id_illegal},
                {m_b.wr, m_b.mr, m_b.mw, m_b.br, m_b.jal, m_b.jalr, m_b.src, m_b.lui,
                 m_b.auipc, m_b.ill});
        end
    endtask

    task automatic drive(logic v, logic [31:0] pc, logic [31:0] ins);
        if_valid = v; if_pc = pc; if_instr = ins;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tab [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = tab[k];
        else if (k == 11) w[6:0] = 7'h6F;
        return w;
    endfunction

    initial begin
        reset = 1; ex_ready = 1; flush = 0;
        drive(0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        cycle(); cycle();
        chk("rst_outputs_zero", {id_valid, jump, pc_imm, id_imm, id_illegal}, '0);
        reset = 0;

        drive(1, 32'h10, 32'h00500093);          // addi x1,x0,5
        cycle();
        chk("addi_valid", id_valid, 1);
        chk("addi_fields", {id_rd, id_rs1, id_imm}, {5'd1, 5'd0, 32'd5});
        chk("addi_flags", {id_reg_write, id_alu_src_imm}, 2'b11);

        drive(1, 32'h14, 32'h0020A423);          // sw x2,8(x1)
        cycle();
        chk("sw_fields", {id_imm, id_rs1, id_rs2, id_funct3}, {32'd8, 5'd1, 5'd2, 3'b010});
        chk("sw_flags", {id_mem_write, id_reg_write}, 2'b10);

        drive(0, 32'h18, 32'h0); cycle();

        drive(1, 32'h20, 32'h008000EF);          // jal x1,+8
        cycle();
        chk("jal_redirect", {jump, pc_imm, id_jal}, {1'b1, 32'h28, 1'b1});
        drive(0, 32'h24, 32'h0); cycle();       // idle beats don't consume the squash
        chk("jal_pulse_once", jump, 0);
        drive(1, 32'h24, 32'h00700293); cycle();
        chk("squash_drop1", id_valid, 0);
        drive(1, 32'h28, 32'h00700293); cycle();
        chk("squash_drop2", id_valid, 0);
        drive(1, 32'h2C, 32'h00700293); cycle();
        chk("squash_third_accept", {id_valid, id_pc}, {1'b1, 32'h2C});

        drive(1, 32'h40, 32'h00500093); cycle();
        ex_ready = 0;
        drive(1, 32'h44, 32'h0020A423);
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("stall_hold", {id_valid, id_pc, if_ready}, {1'b1, 32'h40, 1'b0});
        end
        ex_ready = 1; cycle();
        chk("stall_release", {id_valid, id_pc}, {1'b1, 32'h44});

        drive(1, 32'h50, 32'hFFFFFFFF); cycle();
        chk("illegal", {id_illegal, id_reg_write, id_mem_read, id_mem_write}, 4'b1000);
        drive(1, 32'h54, 32'h00000013); cycle();
        chk("nop", {id_illegal, id_reg_write}, 2'b00);

        drive(1, 32'h60, 32'h008000EF); cycle();
        flush = 1; drive(1, 32'h64, 32'h00500093); cycle();
        chk("flush_kill", {id_valid, jump}, 2'b00);
        flush = 0; drive(1, 32'h68, 32'h00500093); cycle();
        chk("flush_then_accept", {id_valid, id_pc}, {1'b1, 32'h68});

        drive(1, 32'h70, 32'h008000EF); cycle();
        drive(1, 32'h74, 32'h00500093); cycle();
        reset = 1; drive(1, 32'h78, 32'h00500093); cycle();
        chk("rst_mid_squash", {id_valid, jump, pc_imm, id_pc, id_imm, id_rd}, '0);
        reset = 0; cycle();
        chk("rst_then_accept", {id_valid, id_pc}, {1'b1, 32'h78});

        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC, rand_instr());
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
